serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: streams operands LSB-first through one full adder cell.
// Optional SERIAL_ADDER_SUB_EN adds a sub input for a - b (two's complement).

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   a_sr_q, b_sr_q, s_sr_q;
   logic           carry_q;
   logic           busy_q, done_q, cout_q, ovf_q;
   logic [N-1:0]   sum_q;

   logic           fa_sum, fa_cout;
   logic [N-1:0]   s_sr_d;
   logic [N-1:0]   b_cap;
   logic           cin_cap;
   logic           last_bit;

   full_adder u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .s    (fa_sum),
      .cout (fa_cout)
   );

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + 1; the forced carry replaces cin entirely.
   assign b_cap   = sub ? ~b : b;
   assign cin_cap = sub ? 1'b1 : cin;
`else
   assign b_cap   = b;
   assign cin_cap = cin;
`endif

   assign s_sr_d   = {fa_sum, s_sr_q[N-1:1]};
   assign last_bit = (cnt_q == CW'(N - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b_cap;
                  carry_q <= cin_cap;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr_q  <= a_sr_q >> 1;
               b_sr_q  <= b_sr_q >> 1;
               s_sr_q  <= s_sr_d;
               carry_q <= fa_cout;
               cnt_q   <= cnt_q + CW'(1);
               if (last_bit) begin
                  // carry_q still holds the carry into the MSB here.
                  sum_q   <= s_sr_d;
                  cout_q  <= fa_cout;
                  ovf_q   <= carry_q ^ fa_cout;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results,
// a negedge monitor pops them whenever done is seen.

module tb_serial_adder_ctrl;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub = 1'b0;
   logic         sub_sel = 1'b0;
`endif
   logic         busy, done, cout, ovf;
   logic [N-1:0] sum;

   typedef struct {
      logic [N-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   serial_adder_ctrl #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result_sum", sum, e.sum);
            check("result_cout", cout, e.cout);
            check("result_ovf", ovf, e.ovf);
         end
      end
   end

   // One start pulse, operands scrambled right after capture, busy/done cycle-checked.
   task automatic run_op(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic ci,
                         input logic [N-1:0] es, input logic ec, input logic eo);
      @(negedge clk);
      a = ai;
      b = bi;
      cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
      sub = sub_sel;
`endif
      start = 1'b1;
      sb_q.push_back('{es, ec, eo});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = ~ai;
      b = ~bi;
      cin = ~ci;
`ifdef SERIAL_ADDER_SUB_EN
      sub = ~sub_sel;
`endif
      for (int k = 0; k <= N + 1; k++) begin
         if (k > 0) @(negedge clk);
         check("op_busy", busy, (k <= N) ? 1 : 0);
         check("op_done", done, (k == N) ? 1 : 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_sum", sum, 0);
      check("reset_cout", cout, 0);
      check("reset_ovf", ovf, 0);

      run_op(4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1);
      run_op(4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0);
      run_op(4'd7,  4'd7, 1'b1, 4'd15, 1'b0, 1'b1);

      // start held high: accepts at edges 0 and 6 only.
      @(negedge clk);
      a = 4'd2;
      b = 4'd2;
      cin = 1'b0;
      start = 1'b1;
      sb_q.push_back('{4'd4, 1'b0, 1'b0});
      sb_q.push_back('{4'd4, 1'b0, 1'b0});
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("held_busy", busy, (k != 5) ? 1 : 0);
         check("held_done", done, (k == 4 || k == 10) ? 1 : 0);
         if (k >= 1 && k <= 3) begin
            a = 4'hF;
            b = 4'hA;
         end else if (k == 4) begin
            a = 4'd2;
            b = 4'd2;
         end
      end
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("held_idle_busy", busy, 0);

      // Reset during the second SHIFT cycle of 9 + 6.
      @(negedge clk);
      a = 4'd9;
      b = 4'd6;
      cin = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 0);
      check("midrst_ovf", ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (N + 2) @(negedge clk);
      check("midrst_idle_busy", busy, 0);

      run_op(4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
      sub_sel = 1'b1;
      run_op(4'd3, 4'd5, 1'b0, 4'd14, 1'b0, 1'b0);
      run_op(4'd8, 4'd1, 1'b0, 4'd7,  1'b1, 1'b1);
      sub_sel = 1'b0;
      run_op(4'd5, 4'd3, 1'b0, 4'd8,  1'b0, 1'b1);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
